// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris piece generator.
// Also holds the LFSR-state to piece-candidate mapping.
package tetris_pkg;

    localparam int NUM_PIECES = 7;
    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [NUM_PIECES-1:0] FULL_MASK = 7'h7F;

    typedef logic [2:0] piece_t;

    // Low three bits pick the piece; the unused code 7 falls back to bits [5:3].
    function automatic piece_t map_candidate(input logic [LFSR_WIDTH-1:0] s);
        piece_t lo;
        piece_t hi;
        lo = s[2:0];
        hi = s[5:3];
        if (lo != 3'd7) begin
            return lo;
        end
        return (hi == 3'd7) ? 3'd0 : hi;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, with seed load and zero-state guard.
// Exposes the value the register will take on the next edge.
module lfsr16
    import tetris_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [LFSR_WIDTH-1:0] next_state
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [LFSR_WIDTH-1:0] LOAD_VALUE = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_WIDTH-1:0] lfsr_reg;
    logic                  fb;

    assign fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_comb begin
        next_state = {lfsr_reg[14:0], fb};
        if (lfsr_reg == '0) begin
            next_state = 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LOAD_VALUE;
        end else begin
            lfsr_reg <= next_state;
        end
    end

endmodule

// File: rtl/random_num_gen.sv
// Tetromino selector: maps LFSR output to a piece index 0..6, optionally
// dealing from a 7-bag so each aligned group of seven is a permutation.
module random_num_gen
    import tetris_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED     = DEFAULT_SEED,
    parameter bit                    BAG_MODE = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    output piece_t random
);

    logic [LFSR_WIDTH-1:0] lfsr_next;
    piece_t                cand;
    piece_t                pick;
    piece_t                rot_idx [NUM_PIECES];
    logic [NUM_PIECES-1:0] free_vec;
    logic [NUM_PIECES-1:0] used_reg;
    logic [NUM_PIECES-1:0] used_set;
    logic [NUM_PIECES-1:0] used_next;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .next_state(lfsr_next)
    );

    assign cand = map_candidate(lfsr_next);

    // Slot gi of the scan looks at piece (cand + gi) mod 7.
    for (genvar gi = 0; gi < NUM_PIECES; gi++) begin : g_rot
        logic [3:0] sum;
        logic [3:0] wrapped;
        assign sum           = {1'b0, cand} + 4'(gi);
        assign wrapped       = (sum >= 4'd7) ? (sum - 4'd7) : sum;
        assign rot_idx[gi]   = wrapped[2:0];
        assign free_vec[gi]  = ~used_reg[rot_idx[gi]];
    end

    // First free slot in scan order wins; the mask is never full here,
    // because a full bag is cleared on the edge that completes it.
    always_comb begin
        pick = cand;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                pick = rot_idx[i];
            end
        end
    end

    assign used_set  = used_reg | (7'b1 << pick);
    assign used_next = (used_set == FULL_MASK) ? '0 : used_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random   <= 3'd0;
            used_reg <= '0;
        end else if (BAG_MODE) begin
            random   <= pick;
            used_reg <= used_next;
        end else begin
            random   <= cand;
            used_reg <= '0;
        end
    end

endmodule

// File: tb/tb_random_num_gen.sv
// Self-checking bench for random_num_gen: plain, bag and zero-seed instances
// run side by side against a queue-based reference model.
module tb_random_num_gen;

    localparam int RUN_EDGES = 65535;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rnd_plain;
    logic [2:0] rnd_bag;
    logic [2:0] rnd_zero;

    always #5 clk = ~clk;

    random_num_gen #(.SEED(16'hACE1), .BAG_MODE(1'b0)) dut_plain (
        .clk(clk), .rst_n(rst_n), .random(rnd_plain));
    random_num_gen #(.SEED(16'hACE1), .BAG_MODE(1'b1)) dut_bag (
        .clk(clk), .rst_n(rst_n), .random(rnd_bag));
    random_num_gen #(.SEED(16'h0000), .BAG_MODE(1'b1)) dut_zero (
        .clk(clk), .rst_n(rst_n), .random(rnd_zero));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] lfsr;
        logic [2:0]  plain;
        logic [2:0]  bag;
    } vec_t;
    vec_t golden [3];

    // Reference model state
    logic [15:0] m_lfsr;
    logic [15:0] m_zlfsr;
    int          bag_rem[$];
    int          zbag_rem[$];
    int          exp_plain, exp_bag, exp_zero;

    // Scoreboard accumulators
    int edge_n;
    int err_plain, err_bag, err_zero, err_lfsr, err_zlfsr;
    int sevens, early_wrap, bad_groups, bad_zgroups, n_groups;
    int hist [7];
    int grp[$];
    int zgrp[$];
    int first_plain [7];
    int first_bag [7];

    function automatic logic [15:0] model_step(input logic [15:0] s);
        int v;
        if (s == 16'h0000) return 16'h0001;
        v = (int'(s) * 2) % 65536 + ($countones(s & 16'hB400) % 2);
        return 16'(v);
    endfunction

    function automatic int cand_of(input logic [15:0] s);
        int v, lo, hi;
        v  = int'(s);
        lo = v % 8;
        hi = (v / 8) % 8;
        if (lo != 7) return lo;
        return (hi == 7) ? 0 : hi;
    endfunction

    // Deal from the remaining pieces: first one found scanning c, c+1, ... mod 7.
    function automatic int take_from(input int rem[$], input int c);
        for (int d = 0; d < 7; d++) begin
            int p;
            p = (c + d) % 7;
            foreach (rem[k]) if (rem[k] == p) return p;
        end
        return -1;
    endfunction

    function automatic bit is_perm(input int g[$]);
        int seen [7];
        foreach (seen[k]) seen[k] = 0;
        foreach (g[k]) begin
            if (g[k] < 0 || g[k] > 6) return 1'b0;
            seen[g[k]]++;
        end
        foreach (seen[k]) if (seen[k] != 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_zlfsr = 16'h0001;
        bag_rem  = '{0, 1, 2, 3, 4, 5, 6};
        zbag_rem = '{0, 1, 2, 3, 4, 5, 6};
        grp.delete();
        zgrp.delete();
        edge_n = 0;
    endtask

    task automatic model_advance();
        int c;
        m_lfsr    = model_step(m_lfsr);
        m_zlfsr   = model_step(m_zlfsr);
        exp_plain = cand_of(m_lfsr);
        exp_bag   = take_from(bag_rem, exp_plain);
        foreach (bag_rem[k]) if (bag_rem[k] == exp_bag) begin bag_rem.delete(k); break; end
        if (bag_rem.size() == 0) bag_rem = '{0, 1, 2, 3, 4, 5, 6};
        c        = cand_of(m_zlfsr);
        exp_zero = take_from(zbag_rem, c);
        foreach (zbag_rem[k]) if (zbag_rem[k] == exp_zero) begin zbag_rem.delete(k); break; end
        if (zbag_rem.size() == 0) zbag_rem = '{0, 1, 2, 3, 4, 5, 6};
    endtask

    // One clock edge: advance the model and fold the outcome into the tallies.
    task automatic advance_and_score();
        @(posedge clk);
        #1;
        edge_n++;
        model_advance();
        if (edge_n <= 7) begin
            first_plain[edge_n-1] = exp_plain;
            first_bag[edge_n-1]   = exp_bag;
        end
        if (int'(rnd_plain) != exp_plain) err_plain++;
        if (int'(rnd_bag) != exp_bag) err_bag++;
        if (int'(rnd_zero) != exp_zero) err_zero++;
        if (dut_plain.u_lfsr.lfsr_reg !== m_lfsr) err_lfsr++;
        if (dut_zero.u_lfsr.lfsr_reg !== m_zlfsr) err_zlfsr++;
        if (dut_plain.u_lfsr.lfsr_reg == 16'hACE1 && edge_n < RUN_EDGES) early_wrap++;
        if (rnd_plain == 3'd7 || rnd_bag == 3'd7 || rnd_zero == 3'd7) sevens++;
        if (rnd_plain != 3'd7) hist[rnd_plain]++;
        grp.push_back(int'(rnd_bag));
        zgrp.push_back(int'(rnd_zero));
        if (grp.size() == 7) begin
            n_groups++;
            if (!is_perm(grp)) bad_groups++;
            if (!is_perm(zgrp)) bad_zgroups++;
            grp.delete();
            zgrp.delete();
        end
    endtask

    initial begin
        golden[0] = '{"reset",  16'hACE1, 3'd0, 3'd0};
        golden[1] = '{"edge1",  16'h59C3, 3'd3, 3'd3};
        golden[2] = '{"edge2",  16'hB387, 3'd0, 3'd0};

        err_plain = 0; err_bag = 0; err_zero = 0; err_lfsr = 0; err_zlfsr = 0;
        sevens = 0; early_wrap = 0; bad_groups = 0; bad_zgroups = 0; n_groups = 0;
        foreach (hist[k]) hist[k] = 0;

        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d_plain", i), rnd_plain, 0);
            check($sformatf("reset_hold%0d_bag", i), rnd_bag, 0);
        end
        check("reset_zero_seed_lfsr", dut_zero.u_lfsr.lfsr_reg, 16'h0001);
        check("reset_zero_seed_out", rnd_zero, 0);

        // Release mid-cycle; nothing may move before the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("release_no_glitch", rnd_bag, 0);

        for (int g = 0; g < 3; g++) begin
            if (g > 0) advance_and_score();
            check({"golden_", golden[g].name, "_lfsr"}, dut_plain.u_lfsr.lfsr_reg, golden[g].lfsr);
            check({"golden_", golden[g].name, "_plain"}, rnd_plain, golden[g].plain);
            check({"golden_", golden[g].name, "_bag"}, rnd_bag, golden[g].bag);
        end

        while (edge_n < RUN_EDGES) advance_and_score();

        check("plain_stream_errors", err_plain, 0);
        check("bag_stream_errors", err_bag, 0);
        check("zero_seed_stream_errors", err_zero, 0);
        check("lfsr_trace_errors", err_lfsr, 0);
        check("zero_seed_lfsr_errors", err_zlfsr, 0);
        check("lfsr_period_return", dut_plain.u_lfsr.lfsr_reg, 16'hACE1);
        check("lfsr_early_wrap", early_wrap, 0);
        check("outputs_equal_7", sevens, 0);
        check("bag_groups_seen", n_groups, RUN_EDGES / 7);
        check("bag_bad_groups", bad_groups, 0);
        check("zero_seed_bad_groups", bad_zgroups, 0);
        for (int v = 0; v < 7; v++) begin
            check($sformatf("hist_%0d_ge_5000_count_%0d", v, hist[v]), hist[v] >= 5000, 1);
        end

        // Mid-bag reset: four picks into a bag, then an asynchronous pulse.
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_bag_out", rnd_bag, 0);
        check("async_reset_plain_out", rnd_plain, 0);
        check("async_reset_lfsr", dut_bag.u_lfsr.lfsr_reg, 16'hACE1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rebag_%0d", k), rnd_bag, first_bag[k]);
            check($sformatf("replain_%0d", k), rnd_plain, first_plain[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
